veri_phase_comp_coarse_ctrl: RTL

Sequencer for the 2-bit coarse phase register of the high-side phase comparator. It issues one-cycle calibration loads and filters early/late decisions from the phase detector into single coarse steps. For each step it computes the wrapped next code and flags wrap-around to the fine stage. It drives the register's `enable`, `load_en`, `load_data` and `sum_in` inputs and reads back `reg_out`.

---
 rtl/veri_phase_comp_coarse_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/veri_phase_comp_coarse_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : veri_phase_comp_coarse_ctrl                                     |
// | Function : Sequencer for the 2-bit coarse phase register. Issues one-cycle |
// |            calibration loads, filters early/late votes over a window into  |
// |            single wrapped coarse steps, flags carry/borrow to the fine     |
// |            stage and reports lock.                                         |
// | Options  : COARSE_LOCK_DET_EN - include lock counter and locked output;    |
// |            when undefined, locked is tied low.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module veri_phase_comp_coarse_ctrl #(
  parameter int WIN_LEN  = 16,
  parameter int THRESH   = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       cal_start,
  input  logic [1:0] cal_code,
  input  logic       track_en,
  input  logic       up,
  input  logic       dn,
  input  logic [1:0] reg_out,
  output logic       enable,
  output logic       load_en,
  output logic [1:0] load_data,
  output logic [1:0] sum_in,
  output logic       carry_out,
  output logic       borrow_out,
  output logic       busy,
  output logic       locked
);

  localparam int c_VW  = $clog2(WIN_LEN) + 1;  // vote width, signed
  localparam int c_WCW = $clog2(WIN_LEN);      // window counter width
  localparam logic [c_WCW-1:0]       c_WIN_LAST = c_WCW'(WIN_LEN - 1);
  localparam logic signed [c_VW:0]   c_THR_POS  = (c_VW + 1)'(THRESH);
  localparam logic signed [c_VW:0]   c_THR_NEG  = -c_THR_POS;

  // Elaboration-time guard on the legal parameter ranges
  if (WIN_LEN < 2 || WIN_LEN > 256 || THRESH < 1 || THRESH > WIN_LEN ||
      LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_param_err
    $error("veri_phase_comp_coarse_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_TRACK = 2'd2,
    ST_APPLY = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_dir_up;
  logic signed [c_VW-1:0]    r_vote;
  logic        [c_WCW-1:0]   r_win_cnt;
  logic signed [c_VW:0]      w_vote_step;
  logic signed [c_VW:0]      w_vote_nxt;
  logic                      w_win_end;

  // Vote contribution of the current cycle; one extra bit so a full window
  // of identical votes cannot overflow the compare
  always_comb begin
    w_vote_step = '0;
    if (up && !dn)
      w_vote_step = (c_VW + 1)'(1);
    else if (dn && !up)
      w_vote_step = '1;
  end

  assign w_vote_nxt = {r_vote[c_VW-1], r_vote} + w_vote_step;
  assign w_win_end  = (r_win_cnt == c_WIN_LAST);

  // Next-state decode; cal_start overrides everything, then a dropped
  // track_en, then the window-end threshold test
  always_comb begin
    w_state_nxt = r_state;
    if (cal_start) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE:  if (track_en) w_state_nxt = ST_TRACK;
        ST_LOAD,
        ST_APPLY: w_state_nxt = track_en ? ST_TRACK : ST_IDLE;
        ST_TRACK: begin
          if (!track_en)
            w_state_nxt = ST_IDLE;
          else if (w_win_end && (w_vote_nxt >= c_THR_POS || w_vote_nxt <= c_THR_NEG))
            w_state_nxt = ST_APPLY;
        end
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State flop with Moore-registered register controls and latched step direction
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state   <= ST_IDLE;
      enable    <= 1'b0;
      load_en   <= 1'b0;
      busy      <= 1'b0;
      load_data <= 2'b01;
      r_dir_up  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      enable  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_APPLY);
      load_en <= (w_state_nxt == ST_LOAD);
      busy    <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_APPLY);
      if (cal_start)
        load_data <= cal_code;
      if (r_state == ST_TRACK && w_state_nxt == ST_APPLY)
        r_dir_up <= ~w_vote_nxt[c_VW];
    end
  end

  // Vote and window counter run only while staying in TRACK mid-window
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_vote    <= '0;
      r_win_cnt <= '0;
    end else if (r_state == ST_TRACK && w_state_nxt == ST_TRACK && !w_win_end) begin
      r_vote    <= w_vote_nxt[c_VW-1:0];
      r_win_cnt <= r_win_cnt + c_WCW'(1);
    end else begin
      r_vote    <= '0;
      r_win_cnt <= '0;
    end
  end

  // Step value and wrap flags to the register, valid only in APPLY
  always_comb begin
    sum_in     = reg_out;
    carry_out  = 1'b0;
    borrow_out = 1'b0;
    if (r_state == ST_APPLY) begin
      if (r_dir_up) begin
        sum_in    = reg_out + 2'd1;
        carry_out = (reg_out == 2'b11);
      end else begin
        sum_in     = reg_out - 2'd1;
        borrow_out = (reg_out == 2'b00);
      end
    end
  end

`ifdef COARSE_LOCK_DET_EN
  localparam logic [7:0] c_LOCK = 8'(LOCK_CNT);

  logic [7:0] r_lock_cnt;
  logic       r_locked;

  // Count quiet windows (saturating); any non-TRACK state drops lock
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (r_state == ST_TRACK && w_state_nxt == ST_TRACK && w_win_end) begin
      if (r_lock_cnt != c_LOCK)
        r_lock_cnt <= r_lock_cnt + 8'd1;
      if (r_lock_cnt >= c_LOCK - 8'd1)
        r_locked <= 1'b1;
    end else if (r_state != ST_TRACK) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end
  end

  assign locked = r_locked;
`else
  assign locked = 1'b0;
`endif

endmodule
`default_nettype wire
